rounding_rr_scheduler: RTL and testbench

- Shares one combinational rounding unit between NUM_REQ requesters.
- Round-robin arbitration selects one request per cycle and drives the selected operand, rounding mode and sign bit to the unit from an issue register.
- The unit's result is captured, together with the requester ID, into an output register that has valid/ready backpressure.
- Sits between rounding clients (e.g. FP normalisation paths) and the single rounding_module instance.

---
 rtl/rounding_rr_scheduler.sv | 111 +++++++++++
 tb/tb_rounding_rr_scheduler.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rounding_rr_scheduler.sv
// Round-robin front end that shares one combinational rounding unit among NUM_REQ requesters.
// Latency: request accepted at edge N, result valid after edge N+1 (issue reg -> output reg).
// Backpressure: output reg holds while !out_ready; a full issue reg then stalls and drops every req_ready.
module rounding_rr_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int RES_W   = 16,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ*2-1:0]      req_mode,
    input  logic [NUM_REQ-1:0]        req_sign,
    output logic [DATA_W-1:0]         ru_data,
    output logic [1:0]                ru_mode,
    output logic                      ru_sign,
    input  logic [RES_W-1:0]          ru_result,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [RES_W-1:0]          out_result,
    output logic [ID_W-1:0]           out_id,
    output logic [1:0]                out_mode
);

    logic              iss_v;
    logic [DATA_W-1:0] iss_data;
    logic [1:0]        iss_mode;
    logic              iss_sign;
    logic [ID_W-1:0]   iss_id;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   grant;
    logic [ID_W-1:0]   next_ptr;
    logic [ID_W:0]     idx;
    logic              any_req;
    logic              out_adv;
    logic              iss_adv;
    logic              accept;

    // First valid requester at or above rr_ptr, wrapping past NUM_REQ-1.
    always_comb begin
        grant   = '0;
        any_req = 1'b0;
        idx     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (idx >= (ID_W+1)'(NUM_REQ))
                idx = idx - (ID_W+1)'(NUM_REQ);
            if (!any_req && req_valid[idx[ID_W-1:0]]) begin
                any_req = 1'b1;
                grant   = idx[ID_W-1:0];
            end
        end
    end

    assign out_adv  = !out_valid || out_ready;
    assign iss_adv  = !iss_v || out_adv;
    assign accept   = iss_adv && any_req && !rst;
    assign next_ptr = (grant == ID_W'(NUM_REQ-1)) ? '0 : grant + ID_W'(1);

    always_comb begin
        req_ready = '0;
        if (accept)
            req_ready[grant] = 1'b1;
    end

    // Issue fields are cleared when the stage empties, so the unit sees zeros without extra gating.
    assign ru_data = iss_data;
    assign ru_mode = iss_mode;
    assign ru_sign = iss_sign;

    always_ff @(posedge clk) begin
        if (rst) begin
            iss_v      <= 1'b0;
            iss_data   <= '0;
            iss_mode   <= '0;
            iss_sign   <= 1'b0;
            iss_id     <= '0;
            rr_ptr     <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_id     <= '0;
            out_mode   <= '0;
        end else begin
            if (accept) begin
                iss_v    <= 1'b1;
                iss_data <= req_data[grant*DATA_W +: DATA_W];
                iss_mode <= req_mode[grant*2 +: 2];
                iss_sign <= req_sign[grant];
                iss_id   <= grant;
                rr_ptr   <= next_ptr;
            end else if (iss_adv) begin
                iss_v    <= 1'b0;
                iss_data <= '0;
                iss_mode <= '0;
                iss_sign <= 1'b0;
            end
            if (out_adv) begin
                out_valid <= iss_v;
                if (iss_v) begin
                    out_result <= ru_result;
                    out_id     <= iss_id;
                    out_mode   <= iss_mode;
                end
            end
        end
    end

endmodule

// File: tb/tb_rounding_rr_scheduler.sv
// Bench for rounding_rr_scheduler: per-cycle vector table, reset sequence, random traffic with a grant-order scoreboard.
module tb_rounding_rr_scheduler;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   req_valid = '0;
    logic [3:0]   req_ready;
    logic [127:0] req_data;
    logic [7:0]   req_mode;
    logic [3:0]   req_sign;
    logic [31:0]  ru_data;
    logic [1:0]   ru_mode;
    logic         ru_sign;
    logic [15:0]  ru_result;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [15:0]  out_result;
    logic [1:0]   out_id;
    logic [1:0]   out_mode;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    rounding_rr_scheduler #(.NUM_REQ(4), .DATA_W(32), .RES_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_mode  (req_mode),
        .req_sign  (req_sign),
        .ru_data   (ru_data),
        .ru_mode   (ru_mode),
        .ru_sign   (ru_sign),
        .ru_result (ru_result),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_result(out_result),
        .out_id    (out_id),
        .out_mode  (out_mode)
    );

    // Reference rounding unit: keep the top 16 bits, modes RNE / RTZ / toward +inf / toward -inf.
    function automatic logic [15:0] round_fn(input logic [31:0] d, input logic [1:0] m, input logic s);
        logic [15:0] hi;
        logic [15:0] lo;
        logic        inc;
        hi  = d[31:16];
        lo  = d[15:0];
        inc = 1'b0;
        case (m)
            2'd0: inc = lo[15] && ((lo[14:0] != 15'd0) || hi[0]);
            2'd1: inc = 1'b0;
            2'd2: inc = !s && (lo != 16'd0);
            2'd3: inc = s && (lo != 16'd0);
            default: inc = 1'b0;
        endcase
        return hi + {15'd0, inc};
    endfunction

    assign ru_result = round_fn(ru_data, ru_mode, ru_sign);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard in grant order; occupancy also tells whether the issue stage is full.
    typedef struct packed {
        logic [1:0]  id;
        logic [1:0]  mode;
        logic [15:0] res;
    } sb_t;

    sb_t         sb[$];
    int          m_rr = 0;
    logic        prev_acc = 1'b0;
    logic [31:0] prev_data;
    logic [1:0]  prev_mode;
    logic        prev_sign;

    always @(negedge clk) begin
        if (rst) begin
            check("ready_in_reset", {60'd0, req_ready}, 64'd0);
            sb.delete();
            m_rr     = 0;
            prev_acc = 1'b0;
        end else begin
            int   g;
            logic found;
            logic iss_full;
            logic exp_acc;
            logic [3:0] exp_rdy;
            sb_t  e;
            check("ready_onehot0", {63'd0, $onehot0(req_ready)}, 64'd1);
            if (prev_acc) begin
                check("ru_data", {32'd0, ru_data}, {32'd0, prev_data});
                check("ru_mode", {62'd0, ru_mode}, {62'd0, prev_mode});
                check("ru_sign", {63'd0, ru_sign}, {63'd0, prev_sign});
            end
            g     = 0;
            found = 1'b0;
            for (int k = 0; k < 4; k++) begin
                int ix;
                ix = (m_rr + k) % 4;
                if (!found && req_valid[ix]) begin
                    found = 1'b1;
                    g     = ix;
                end
            end
            iss_full = (sb.size() > int'(out_valid));
            exp_acc  = found && (!iss_full || !out_valid || out_ready);
            exp_rdy  = exp_acc ? (4'b0001 << g) : 4'b0000;
            check("grant", {60'd0, req_ready}, {60'd0, exp_rdy});
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("spurious_result", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("out_id", {62'd0, out_id}, {62'd0, e.id});
                    check("out_mode", {62'd0, out_mode}, {62'd0, e.mode});
                    check("out_result", {48'd0, out_result}, {48'd0, e.res});
                end
            end
            if (exp_acc) begin
                prev_data = req_data[g*32 +: 32];
                prev_mode = req_mode[g*2 +: 2];
                prev_sign = req_sign[g];
                e.id   = 2'(g);
                e.mode = prev_mode;
                e.res  = round_fn(prev_data, prev_mode, prev_sign);
                sb.push_back(e);
                m_rr = (g == 3) ? 0 : g + 1;
            end
            prev_acc = exp_acc;
        end
    end

    typedef struct {
        logic [3:0] rv;
        logic       ordy;
        logic [3:0] rdy;
        logic       ov;
        logic [1:0] oid;
    } vec_t;

    vec_t tbl[27];

    initial begin
        // Requester 1 carries the reference operand; the others exercise ties and carries.
        req_data = {32'h7FFF0001, 32'h0001FFFF, 32'h12345678, 32'hA0018000};
        req_mode = {2'd1, 2'd3, 2'd2, 2'd0};
        req_sign = 4'b0110;

        // Single requester 1, streaming.
        tbl[0]  = '{4'b0010, 1'b1, 4'b0010, 1'b0, 2'd0};
        tbl[1]  = '{4'b0010, 1'b1, 4'b0010, 1'b0, 2'd0};
        tbl[2]  = '{4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1};
        // All four valid: rotation continues from pointer 2 and wraps 3 -> 0.
        tbl[3]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd1};
        tbl[4]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd1};
        tbl[5]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd2};
        tbl[6]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd3};
        tbl[7]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd0};
        tbl[8]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd1};
        tbl[9]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd2};
        tbl[10] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd3};
        // out_ready low 5 cycles with 0 and 2 valid: two accepts, then stall.
        tbl[11] = '{4'b0101, 1'b0, 4'b0001, 1'b0, 2'd0};
        tbl[12] = '{4'b0101, 1'b0, 4'b0100, 1'b0, 2'd0};
        tbl[13] = '{4'b0101, 1'b0, 4'b0000, 1'b1, 2'd0};
        tbl[14] = '{4'b0101, 1'b0, 4'b0000, 1'b1, 2'd0};
        tbl[15] = '{4'b0101, 1'b0, 4'b0000, 1'b1, 2'd0};
        tbl[16] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0};
        tbl[17] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd2};
        tbl[18] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};
        // Pointer at 3 after granting 2: grant 3, then 2, then 2 alone; idle keeps pointer.
        tbl[19] = '{4'b1100, 1'b1, 4'b1000, 1'b0, 2'd0};
        tbl[20] = '{4'b1100, 1'b1, 4'b0100, 1'b0, 2'd0};
        tbl[21] = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd3};
        tbl[22] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd2};
        tbl[23] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd2};
        tbl[24] = '{4'b0110, 1'b1, 4'b0010, 1'b0, 2'd0};
        tbl[25] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};
        tbl[26] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd1};

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_out_valid", {63'd0, out_valid}, 64'd0);
        check("reset_ru_data", {32'd0, ru_data}, 64'd0);
        check("reset_out_result", {48'd0, out_result}, 64'd0);

        for (int i = 0; i < 27; i++) begin
            @(posedge clk);
            #1;
            req_valid = tbl[i].rv;
            out_ready = tbl[i].ordy;
            @(negedge clk);
            check($sformatf("vec%0d_ready", i), {60'd0, req_ready}, {60'd0, tbl[i].rdy});
            check($sformatf("vec%0d_out_valid", i), {63'd0, out_valid}, {63'd0, tbl[i].ov});
            if (tbl[i].ov)
                check($sformatf("vec%0d_out_id", i), {62'd0, out_id}, {62'd0, tbl[i].oid});
        end

        // Fill both stages (grants 0 then 1, pointer ends at 2), then reset mid-flight.
        @(posedge clk);
        #1;
        req_valid = 4'b0011;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("full_ready", {60'd0, req_ready}, 64'd0);
        check("full_out_valid", {63'd0, out_valid}, 64'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rst_ready", {60'd0, req_ready}, 64'd0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        req_valid = 4'b0110;
        @(negedge clk);
        check("post_rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("post_rst_ru_data", {32'd0, ru_data}, 64'd0);
        check("post_rst_ru_mode", {62'd0, ru_mode}, 64'd0);
        check("post_rst_ru_sign", {63'd0, ru_sign}, 64'd0);
        check("post_rst_grant", {60'd0, req_ready}, 64'd2);
        @(posedge clk);
        #1 req_valid = 4'b0000;
        repeat (3) @(posedge clk);

        // Random traffic, random backpressure.
        for (int c = 0; c < 10000; c++) begin
            @(posedge clk);
            #1;
            req_valid = 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            for (int r = 0; r < 4; r++) begin
                req_data[r*32 +: 32] = $urandom;
                req_mode[r*2 +: 2]   = 2'($urandom);
            end
            req_sign = 4'($urandom);
        end

        @(posedge clk);
        #1;
        req_valid = 4'b0000;
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
